prim_serdes: RTL and testbench

Parametrised full-duplex serializer/deserializer, the successor of the plain SIPO shift register primitive. One frame loads a parallel word, shifts it out serially while shifting the same number of bits in, then presents the received word with a valid/ready handshake. Bit order is selectable per frame. It sits under SPI-like and bit-banged peripheral controllers of the SoC, which supply the bit-rate strobe.

---
 rtl/prim_serdes_pkg.sv | 16 +
 rtl/prim_serdes_if.sv | 26 ++
 rtl/prim_serdes_bitcnt.sv | 37 +++
 rtl/prim_serdes.sv | 145 ++++++++++++++
 tb/tb_prim_serdes.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/prim_serdes_pkg.sv
// prim_serdes_pkg: shared types and helpers for the prim_serdes slice.
//   serdes_state_e : frame FSM state encoding (idle / shifting).
//   cnt_w()        : bit-counter width for a frame of a given length.
package prim_serdes_pkg;

    typedef enum logic [0:0] {
        SerIdle  = 1'b0,
        SerShift = 1'b1
    } serdes_state_e;

    // Counter width able to hold 0..width-1; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 32'sd2) ? $clog2(width) : 32'sd1;
    endfunction

endpackage

// File: rtl/prim_serdes_if.sv
// prim_serdes_if: parallel-side handshakes of prim_serdes.
//   tx_valid/tx_ready/tx_data : word offered for transmission.
//   rx_valid/rx_ready/rx_data : received word towards the consumer.
//   rx_overrun                : one-cycle pulse when an unaccepted word is overwritten.
//   master modport: producer/consumer side; slave modport: the serdes.
interface prim_serdes_if #(
    parameter int WIDTH = 8
);
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_overrun;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, rx_valid, rx_data, rx_overrun
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, rx_valid, rx_data, rx_overrun
    );
endinterface

// File: rtl/prim_serdes_bitcnt.sv
// prim_serdes_bitcnt: counts shifted bits of the current frame.
//   clk_i, rst_ni : clock, asynchronous active-low reset.
//   clr_i         : synchronous clear to zero (priority over en_i).
//   en_i          : increment by one.
//   last_o        : count equals WIDTH-1 (next strobe ends the frame).
module prim_serdes_bitcnt
    import prim_serdes_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LastVal = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_r;

    // Bit counter register; the frame ends at WIDTH-1 so it never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CW{1'b0}};
        end else if (en_i) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last_o = (cnt_r == LastVal);

endmodule

// File: rtl/prim_serdes.sv
// prim_serdes: full-duplex serializer/deserializer.
//   clk_i, rst_ni : clock, asynchronous active-low reset.
//   clr_i         : synchronous abort of the current frame.
//   en_i          : bit strobe, one shift per strobe while shifting.
//   msb_first_i   : bit order, captured at frame load.
//   serial_i/o    : serial input / output bit.
//   busy_o        : frame in progress.
//   bus           : tx/rx handshakes and overrun pulse (slave modport).
module prim_serdes
    import prim_serdes_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             msb_first_i,
    input  logic             serial_i,
    output logic             serial_o,
    output logic             busy_o,
    prim_serdes_if.slave     bus
);
    if (WIDTH < 2) begin : g_width_check
        $error("prim_serdes: WIDTH must be at least 2");
    end

    serdes_state_e    state_r, state_n;
    logic [WIDTH-1:0] shreg_r, shreg_n, shifted_s;
    logic             dir_r, dir_n;
    logic [WIDTH-1:0] rx_data_r, rx_data_n;
    logic             rx_valid_r, rx_valid_n;
    logic             overrun_r, overrun_n;
    logic             serial_r, serial_n;
    logic             busy_r;
    logic             cnt_clr_s, cnt_en_s, cnt_last_s;

    // Bit presented on the line for a given register value and bit order.
    function automatic logic out_bit(input logic [WIDTH-1:0] v, input logic msb);
        return msb ? v[WIDTH-1] : v[0];
    endfunction

    prim_serdes_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr_s),
        .en_i   (cnt_en_s),
        .last_o (cnt_last_s)
    );

    // Shift register value after one strobe in the frame's bit order.
    always_comb begin
        if (dir_r) begin
            shifted_s = {shreg_r[WIDTH-2:0], serial_i};
        end else begin
            shifted_s = {serial_i, shreg_r[WIDTH-1:1]};
        end
    end

    // Next-state, datapath and handshake logic of the frame FSM.
    always_comb begin
        state_n    = state_r;
        shreg_n    = shreg_r;
        dir_n      = dir_r;
        rx_data_n  = rx_data_r;
        rx_valid_n = rx_valid_r && !bus.rx_ready;
        overrun_n  = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_r)
            SerIdle: begin
                if (!clr_i && bus.tx_valid) begin
                    shreg_n   = bus.tx_data;
                    dir_n     = msb_first_i;
                    cnt_clr_s = 1'b1;
                    state_n   = SerShift;
                end else begin
                    state_n = SerIdle;
                end
            end
            SerShift: begin
                if (clr_i) begin
                    cnt_clr_s = 1'b1;
                    state_n   = SerIdle;
                end else if (en_i) begin
                    shreg_n = shifted_s;
                    if (cnt_last_s) begin
                        // A still-pending word is only overrun if not taken this cycle.
                        cnt_clr_s  = 1'b1;
                        rx_data_n  = shifted_s;
                        rx_valid_n = 1'b1;
                        overrun_n  = rx_valid_r && !bus.rx_ready;
                        state_n    = SerIdle;
                    end else begin
                        cnt_en_s = 1'b1;
                    end
                end else begin
                    state_n = SerShift;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                state_n   = SerIdle;
            end
        endcase
        // Line level is registered from next-state values so it is glitch-free.
        if (state_n == SerShift) begin
            serial_n = out_bit(shreg_n, dir_n);
        end else begin
            serial_n = IDLE_LVL;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= SerIdle;
            shreg_r    <= {WIDTH{1'b0}};
            dir_r      <= 1'b0;
            rx_data_r  <= {WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
            serial_r   <= IDLE_LVL;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            shreg_r    <= shreg_n;
            dir_r      <= dir_n;
            rx_data_r  <= rx_data_n;
            rx_valid_r <= rx_valid_n;
            overrun_r  <= overrun_n;
            serial_r   <= serial_n;
            busy_r     <= (state_n == SerShift);
        end
    end

    assign bus.tx_ready   = (state_r == SerIdle) && !clr_i;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_overrun = overrun_r;
    assign serial_o       = serial_r;
    assign busy_o         = busy_r;

endmodule

// File: tb/tb_prim_serdes.sv
// tb_prim_serdes: randomized self-checking bench for prim_serdes (WIDTH=8).
// The reference model is frame-level: expected line bits are taken straight
// from the loaded word in the chosen order, and the expected received word is
// assembled from the bits the bench drives onto serial_i.
module tb_prim_serdes;
    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic clk_i       = 1'b0;
    logic rst_ni      = 1'b0;
    logic clr_i       = 1'b0;
    logic en_i        = 1'b0;
    logic msb_first_i = 1'b0;
    logic serial_i    = 1'b0;
    logic serial_o;
    logic busy_o;

    prim_serdes_if #(.WIDTH(W)) bus ();

    prim_serdes #(.WIDTH(W), .IDLE_LVL(IDLE)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .en_i        (en_i),
        .msb_first_i (msb_first_i),
        .serial_i    (serial_i),
        .serial_o    (serial_o),
        .busy_o      (busy_o),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit pending  = 1'b0;   // model: a received word is waiting for the consumer

    // Single comparison point of the bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic consume();
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
        check_eq("rx_valid_consumed", bus.rx_valid, 1'b0);
        check_eq("overrun_idle", bus.rx_overrun, 1'b0);
        pending = 1'b0;
    endtask

    // in_mode: 0 loopback, 1 constant one, 2 random bits.
    // abort_kind: 0 none, 1 clr_i, 2 rst_ni, applied after abort_after strobes.
    task automatic send_frame(input logic [7:0] word, input logic msb, input int in_mode,
                              input int period, input bit ready_at_end,
                              input int abort_kind, input int abort_after);
        logic [7:0] rx_exp;
        logic       ob, ib;
        int         busy_cnt;
        check_eq("tx_ready_before_load", bus.tx_ready, 1'b1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = word;
        msb_first_i  = msb;
        en_i         = 1'($urandom_range(0, 1));   // strobe in idle must be ignored
        step();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        msb_first_i  = 1'($urandom);                // order must stay latched
        en_i         = 1'b0;
        busy_cnt     = busy_o ? 1 : 0;
        check_eq("busy_after_load", busy_o, 1'b1);
        check_eq("tx_ready_busy", bus.tx_ready, 1'b0);
        check_eq("overrun_pulse_width", bus.rx_overrun, 1'b0);
        rx_exp = 8'h00;
        for (int i = 0; i < W; i++) begin
            ob = msb ? word[7-i] : word[i];
            check_eq("serial_bit", serial_o, ob);
            check_eq("rx_valid_hold", bus.rx_valid, pending);
            if (abort_kind == 1 && i == abort_after) begin
                clr_i = 1'b1;
                #1;
                check_eq("tx_ready_clr", bus.tx_ready, 1'b0);
                step();
                clr_i = 1'b0;
                #1;
                check_eq("clr_busy", busy_o, 1'b0);
                check_eq("clr_serial_idle", serial_o, IDLE);
                check_eq("clr_tx_ready", bus.tx_ready, 1'b1);
                check_eq("clr_rx_valid", bus.rx_valid, pending);
                step();
                check_eq("clr_no_valid", bus.rx_valid, pending);
                check_eq("clr_no_overrun", bus.rx_overrun, 1'b0);
                return;
            end
            if (abort_kind == 2 && i == abort_after) begin
                #2;
                rst_ni = 1'b0;
                #1;
                check_eq("rst_serial", serial_o, IDLE);
                check_eq("rst_busy", busy_o, 1'b0);
                check_eq("rst_rx_valid", bus.rx_valid, 1'b0);
                check_eq("rst_rx_data", bus.rx_data, 8'h00);
                check_eq("rst_overrun", bus.rx_overrun, 1'b0);
                check_eq("rst_tx_ready", bus.tx_ready, 1'b1);
                pending = 1'b0;
                #2;
                rst_ni = 1'b1;
                step();
                check_eq("rst_release_tx_ready", bus.tx_ready, 1'b1);
                return;
            end
            for (int g = 0; g < period - 1; g++) begin
                step();
                if (busy_o) busy_cnt++;
                check_eq("serial_stall", serial_o, ob);
                check_eq("rx_valid_stall", bus.rx_valid, pending);
            end
            ib = (in_mode == 0) ? ob : (in_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            rx_exp[msb ? 7 - i : i] = ib;
            serial_i = ib;
            en_i     = 1'b1;
            if (i == W - 1 && ready_at_end) bus.rx_ready = 1'b1;
            step();
            en_i         = 1'b0;
            bus.rx_ready = 1'b0;
            if (busy_o) busy_cnt++;
        end
        check_eq("rx_valid_end", bus.rx_valid, 1'b1);
        check_eq("rx_data_end", bus.rx_data, rx_exp);
        check_eq("overrun_end", bus.rx_overrun, (pending && !ready_at_end) ? 1'b1 : 1'b0);
        check_eq("busy_end", busy_o, 1'b0);
        check_eq("serial_idle_end", serial_o, IDLE);
        check_eq("tx_ready_end", bus.tx_ready, 1'b1);
        check_eq("busy_cycles", busy_cnt, 8 * period);
        pending = 1'b1;
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        #3;
        check_eq("reset_serial", serial_o, IDLE);
        check_eq("reset_busy", busy_o, 1'b0);
        check_eq("reset_rx_valid", bus.rx_valid, 1'b0);
        check_eq("reset_rx_data", bus.rx_data, 8'h00);
        check_eq("reset_overrun", bus.rx_overrun, 1'b0);
        check_eq("reset_tx_ready", bus.tx_ready, 1'b1);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        step();

        // Loopback MSB-first, strobe every cycle.
        send_frame(8'hA5, 1'b1, 0, 1, 1'b0, 0, 0);
        consume();
        // LSB-first, serial_i tied high, strobe every third cycle.
        send_frame(8'h01, 1'b0, 1, 3, 1'b0, 0, 0);
        consume();
        // Abort after three strobes, then a clean frame.
        send_frame(8'h3C, 1'b1, 0, 1, 1'b0, 1, 3);
        send_frame(8'hC3, 1'b1, 0, 1, 1'b0, 0, 0);
        consume();
        // Back-to-back frames without consuming: overrun on the second.
        send_frame(8'h11, 1'b1, 0, 1, 1'b0, 0, 0);
        send_frame(8'h22, 1'b1, 0, 1, 1'b0, 0, 0);
        consume();
        // Clear and offer together in idle: no load.
        clr_i        = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h5A;
        #1;
        check_eq("clr_idle_tx_ready", bus.tx_ready, 1'b0);
        step();
        check_eq("clr_idle_busy", busy_o, 1'b0);
        clr_i        = 1'b0;
        bus.tx_valid = 1'b0;
        step();
        check_eq("clr_idle_busy_later", busy_o, 1'b0);
        // Reset mid-frame with a word pending, then a full frame.
        send_frame(8'h96, 1'b0, 2, 1, 1'b0, 0, 0);
        send_frame(8'h69, 1'b1, 0, 2, 1'b0, 2, 4);
        send_frame(8'hE7, 1'b0, 0, 1, 1'b0, 0, 0);
        // Completion with a pending word taken in the same cycle: no overrun.
        send_frame(8'h4B, 1'b1, 2, 1, 1'b1, 0, 0);
        consume();
        // Random frames.
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 1) == 0) ? 0 : 2,
                       $urandom_range(1, 3), 1'($urandom_range(0, 1)), 0, 0);
            if ($urandom_range(0, 1) == 1) consume();
        end
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
